// File: rtl/led_scroll_controller.sv
// Scrolling message sequencer: 16-entry character buffer, four registered digit codes.
// Optional blank gap between repeats: define LED_SCROLL_BLANK_GAP_EN.
module led_scroll_controller #(
    parameter int unsigned MSG_MAX       = 16,
    parameter int unsigned SCROLL_CYCLES = 3125000,
    parameter logic [3:0]  BLANK_CODE    = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [4:0] msg_len,
    input  logic       start,
    input  logic       stop,
    output logic       busy,
    output logic       wrap,
    output logic [3:0] char3,
    output logic [3:0] char2,
    output logic [3:0] char1,
    output logic [3:0] char0
);

`ifdef LED_SCROLL_BLANK_GAP_EN
    localparam int unsigned PtrW   = 5;
    localparam logic [4:0]  GapLen = 5'd4;
`else
    localparam int unsigned PtrW   = 4;
    localparam logic [4:0]  GapLen = 5'd0;
`endif
    localparam logic [23:0] TimerLast = 24'(SCROLL_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_t;

    state_t          state_q, state_d;
    logic [23:0]     timer_q, timer_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [4:0]      len_q, len_d;
    logic            wrap_q, wrap_d;
    logic [3:0]      buf_q [MSG_MAX];
    logic [3:0]      char_q [4];

    logic [4:0] seq_last;
    logic [4:0] ptr_ext;
    logic [4:0] len_clamped;
    logic [4:0] pos3, pos2, pos1, pos0;

    // Increment a sequence position, wrapping after the last one.
    function automatic logic [4:0] next_pos(logic [4:0] p, logic [4:0] last);
        return (p == last) ? 5'd0 : p + 5'd1;
    endfunction

    assign seq_last    = len_q + GapLen - 5'd1;
    assign ptr_ext     = 5'(ptr_q);
    assign len_clamped = (msg_len == 5'd0 || msg_len > 5'd16) ? 5'd16 : msg_len;

    assign pos3 = ptr_ext;
    assign pos2 = next_pos(pos3, seq_last);
    assign pos1 = next_pos(pos2, seq_last);
    assign pos0 = next_pos(pos1, seq_last);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        wrap_d  = 1'b0;
        case (state_q)
            StIdle: begin
                ptr_d = '0;
                if (start && !stop) begin
                    state_d = StRun;
                    timer_d = '0;
                    len_d   = len_clamped;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StPause;
                end else if (timer_q == TimerLast) begin
                    timer_d = '0;
                    ptr_d   = PtrW'(next_pos(ptr_ext, seq_last));
                    wrap_d  = (ptr_ext == seq_last);
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            StPause: begin
                if (start && !stop) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            ptr_q   <= '0;
            len_q   <= 5'd16;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            wrap_q  <= wrap_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(MSG_MAX); i++) begin
                buf_q[i] <= 4'h0;
            end
        end else if (wr_en) begin
            buf_q[wr_addr] <= wr_data;
        end
    end

    // Positions at or past len_q only exist in the blank gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                char_q[k] <= 4'h0;
            end
        end else begin
            char_q[3] <= (pos3 < len_q) ? buf_q[pos3[3:0]] : BLANK_CODE;
            char_q[2] <= (pos2 < len_q) ? buf_q[pos2[3:0]] : BLANK_CODE;
            char_q[1] <= (pos1 < len_q) ? buf_q[pos1[3:0]] : BLANK_CODE;
            char_q[0] <= (pos0 < len_q) ? buf_q[pos0[3:0]] : BLANK_CODE;
        end
    end

    assign busy  = (state_q == StRun);
    assign wrap  = wrap_q;
    assign char3 = char_q[3];
    assign char2 = char_q[2];
    assign char1 = char_q[1];
    assign char0 = char_q[0];

endmodule

// File: doc/led_scroll_controller.md
Name: led_scroll_controller

Overview:
- Sequencer that feeds the four-digit 7-segment driver path with a message scrolling from right to left.
- Holds a 16-entry buffer of 4-bit character codes, written by a simple write port.
- Advances a display window one character every SCROLL_CYCLES clocks and presents four registered character codes, one per digit.
- Sits between user or control logic and the digit-multiplexing fsm/LEDdecoder pair, in the divided-clock domain.

Parameters:
- MSG_MAX, 16: buffer depth in characters; fixed at 16, so address width is 4.
- SCROLL_CYCLES, 3125000: clocks per scroll step (1 s at 3.125 MHz); legal range 2 to 2^24-1.
- BLANK_CODE, 4'hF: character code driven for blank positions (used only with the optional feature).

Ports:
- clk  in  1  single clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to clk.
- wr_en  in  1  buffer write strobe; one character per cycle.
- wr_addr  in  4  buffer write address.
- wr_data  in  4  character code to write.
- msg_len  in  5  message length; sampled only on start.
- start  in  1  one-cycle pulse; begins or resumes scrolling.
- stop  in  1  one-cycle pulse; pauses scrolling.
- busy  out  1  high in RUN.
- wrap  out  1  one-cycle pulse when the window returns to position 0.
- char3  out  4  leftmost digit code.
- char2  out  4  second digit code.
- char1  out  4  third digit code.
- char0  out  4  rightmost digit code.

Behaviour:
- Reset (reset=0): buffer all 4'h0, ptr=0, timer=0, len_q=16, state IDLE; busy=0, wrap=0, char3..char0=4'h0.
- Length: len_q is captured from msg_len on start in IDLE. 0 or >16 clamps to 16. Positions are computed modulo len_q.
- Outputs: registered. Each cycle, charK = buf[(ptr + 3 - K) mod len_q], so char3 shows buf[ptr]. Latency is 1 cycle from a ptr change or buffer write to the outputs.
- Writes: accepted in every state. A write to a displayed address appears on the outputs 2 cycles after the wr_en edge (buffer update, then output register).
- IDLE:
  - ptr held at 0; outputs show the static window.
  - start -> RUN, with timer=0 and len_q captured.
  - stop is ignored.
- RUN:
  - timer increments each cycle. At SCROLL_CYCLES-1: timer=0 and ptr advances.
  - If the old ptr was len_q-1, ptr wraps to 0 and wrap pulses in the same cycle ptr updates.
  - stop -> PAUSE.
- PAUSE:
  - timer and ptr frozen; busy=0.
  - start -> RUN, resuming the same timer value; len_q is not resampled.
- Simultaneous start and stop: stop wins. In IDLE both are ignored.
- Abort: asserting reset mid-scroll returns to the reset values asynchronously. There is no other abort path.
- len_q=1: all four digits show buf[0]; wrap pulses every step.
- Timer width is 24 bits. No overflow is possible within the legal range.

Optional Feature:
- Macro: LED_SCROLL_BLANK_GAP_EN.
- Defined:
  - The effective sequence length becomes len_q+4.
  - Positions len_q..len_q+3 read as BLANK_CODE, giving a blank gap before the message repeats.
  - wrap fires when ptr goes from len_q+3 to 0.
  - ptr width grows to 5 bits.
- Undefined: the sequence length is len_q; no blanks are inserted and BLANK_CODE is unused.

Test Plan:
- Reset/static: hold reset=0 mid-cycle -> all outputs 0 asynchronously. Release, write buf[0..3]=1,2,3,4 -> char3..0=1,2,3,4 after 2 cycles; busy=0.
- Scroll and wrap: SCROLL_CYCLES=4, buf=0..7, msg_len=8, start.
  - First step exactly 4 cycles after start, then char3..0=1,2,3,4.
  - After 8 steps, ptr=0 with a single-cycle wrap.
  - Step 6 shows 6,7,0,1 (wraps modulo 8).
- Pause/resume: stop after 2 timer cycles, hold 10 cycles -> no change, busy=0. start -> next step after exactly 2 more cycles.
- Start and stop asserted in the same cycle during RUN -> PAUSE. In IDLE -> stays IDLE.
- Clamp and short message: msg_len=0 -> behaves as 16. msg_len=1, buf[0]=9 -> all digits 9, wrap every step.
- Live write: during RUN, write the address at char3 -> new code on char3 2 cycles later; the scroll timer is undisturbed.
- Gap, with LED_SCROLL_BLANK_GAP_EN only: msg_len=4, buf=1,2,3,4 -> step 1 shows 2,3,4,F. wrap comes after 8 steps.
